ped_signal_ctrl: RTL
====================

Name: ped_signal_ctrl

Overview:
- Pedestrian signal stage directly downstream of the four-way traffic light controller.
- Consumes the per-approach one-hot light codes (RED=3'b001, YELLOW=3'b010, GREEN=3'b100).
- Latches push-button requests for two crosswalk channels: NS (parallel to north/south traffic) and EW.
- Drives WALK / DONT_WALK (steady or flashing) for each channel, granting WALK only inside the parallel green phase.

Parameters:
- T_WALK, 30, cycles of steady WALK after grant.
- T_FLASH, 16, cycles of flashing DONT_WALK after WALK; T_WALK+T_FLASH must not exceed the controller's green time (50).
- FLASH_HALF, 4, cycles per flash half-period; must be >=1.
- CNT_W, 8, channel counter width; must hold max(T_WALK, T_FLASH).

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- ns_light  input  3  one-hot light code of the north/south approaches (north output of controller)
- ew_light  input  3  one-hot light code of the east/west approaches (east output of controller)
- ped_req_ns  input  1  NS crosswalk button, level or pulse, synchronous to clk
- ped_req_ew  input  1  EW crosswalk button
- ns_walk  output  1  NS WALK lamp
- ns_dont_walk  output  1  NS DONT_WALK lamp
- ns_pending  output  1  NS request latched, not yet served
- ew_walk, ew_dont_walk, ew_pending  output  1 each  same meaning for EW
- light_fault  output  1  sticky; set when either light input is not a legal one-hot code

Behaviour:
- Two identical independent channels; each has a state register, CNT_W counter, pending flag and prev_green flag.
- green = (light == 3'b100). Illegal or non-one-hot codes count as not green.
- green_rise = green & ~prev_green. prev_green resets to 0, so a light already GREEN after reset produces a rise in the first cycle.
- Reset values:
  - state=DONT_WALK, counter=0, pending=0, prev_green=0, light_fault=0.
  - Outputs: walk=0, dont_walk=1, pending=0.
- Request latch:
  - pending set on any cycle with req=1.
  - pending cleared on the cycle WALK is entered. A req in that same cycle does not re-set it; the grant consumes it.
  - A req during WALK/FLASH sets pending for the next green.
- States and transitions (registered, evaluated each posedge):
  - DONT_WALK: if green_rise & (pending | req) -> WALK, counter=0. Otherwise stay.
  - WALK: if ~green -> DONT_WALK (abort). Else if counter==T_WALK-1 -> FLASH, counter=0. Else counter+1.
  - FLASH: if ~green -> DONT_WALK (abort). Else if counter==T_FLASH-1 -> DONT_WALK. Else counter+1.
  - A grant occurs only on green_rise. A request arriving mid-green waits for the next green of that channel.
- Output decode (from registered state/counter only; no combinational input-to-output path):
  - DONT_WALK: walk=0, dont_walk=1.
  - WALK: walk=1, dont_walk=0.
  - FLASH: walk=0, dont_walk = ((counter / FLASH_HALF) even) ? 1 : 0.
- Latency: light becomes GREEN at posedge N (sampled in cycle N) -> walk=1 from posedge N+1. Abort: green drops in cycle M -> dont_walk steady from posedge M+1.
- Safety invariant: walk=1 only while prev_green=1. walk and dont_walk are never both 1.
- light_fault: set on any cycle where a light input is not one of the three legal codes; cleared only by rst. The fault does not alter channel behaviour beyond the not-green rule.
- Reset mid-operation forces all reset values immediately (async).

Optional Feature:
- Macro PED_COUNTDOWN_EN.
- Defined: adds outputs ns_countdown and ew_countdown, each CNT_W wide.
  - In FLASH: value = T_FLASH-1-counter.
  - Otherwise: 0.
  - Registered-state decode, same timing as the lamps.
- Undefined: the ports are absent; no countdown logic.

Decomposition:
- Shared package ped_pkg:
  - light codes LIGHT_RED/LIGHT_YELLOW/LIGHT_GREEN (matching the controller's encoding).
  - channel state enum PED_DONT_WALK/PED_WALK/PED_FLASH (2-bit).
- Sub-module ped_channel: one crosswalk channel (state, counter, pending, prev_green, decode), instantiated twice.
- The top level holds light_fault and the port mapping.

Test Plan:
- Reset with ns_light=GREEN, no req: ns_walk=0, ns_dont_walk=1 for the entire green. ns_pending=0.
- Pulse ped_req_ns 1 cycle during EW green: ns_pending=1. NS goes GREEN at cycle N:
  - ns_walk=1 at N+1..N+30, ns_pending=0 from N+1.
  - Flash N+31..N+46, with dont_walk pattern 1111_0000_1111_0000.
  - Steady dont_walk from N+47.
- ped_req_ns asserted in the same cycle as the NS green rise with pending=0: WALK from the next cycle; pending stays 0.
- Grant NS, then drop ns_light to YELLOW at WALK cycle 10: next cycle ns_walk=0, ns_dont_walk=1 steady. ns_pending stays 0.
- Req during NS WALK: pending=1 stays through yellow/red/EW phases; served at the next NS green rise. The EW channel is unaffected throughout.
- Drive ns_light=3'b011 for 1 cycle: light_fault=1 and stays set until rst. With PED_COUNTDOWN_EN defined, ns_countdown reads 15..0 across FLASH.

Source files
------------

// File: rtl/ped_pkg.sv
// Shared light codes and pedestrian channel state encoding for the crosswalk stage.
package ped_pkg;

    localparam logic [2:0] LIGHT_RED    = 3'b001;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_GREEN  = 3'b100;

    typedef logic [1:0] ped_state_t;

    localparam ped_state_t PED_DONT_WALK = 2'd0;
    localparam ped_state_t PED_WALK      = 2'd1;
    localparam ped_state_t PED_FLASH     = 2'd2;

    function automatic logic light_legal(input logic [2:0] light);
        return (light == LIGHT_RED) || (light == LIGHT_YELLOW) || (light == LIGHT_GREEN);
    endfunction

endpackage

// File: rtl/ped_channel.sv
// One crosswalk channel: request latch, WALK/FLASH sequencing on green rise, registered lamp decode.
// Optional countdown output when PED_COUNTDOWN_EN is defined.
module ped_channel
    import ped_pkg::*;
#(
    parameter int unsigned T_WALK     = 30,
    parameter int unsigned T_FLASH    = 16,
    parameter int unsigned FLASH_HALF = 4,
    parameter int unsigned CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       light,
    input  logic             req,
    output logic             walk,
    output logic             dont_walk,
    output logic             pending
`ifdef PED_COUNTDOWN_EN
    ,
    output logic [CNT_W-1:0] countdown
`endif
);

    ped_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pending_q, pending_d;
    logic             prev_green_q, prev_green_d;
    logic             walk_q, walk_d;
    logic             dont_walk_q, dont_walk_d;
    logic             green, green_rise;
    logic [CNT_W-1:0] flash_phase;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= PED_DONT_WALK;
            cnt_q        <= '0;
            pending_q    <= 1'b0;
            prev_green_q <= 1'b0;
            walk_q       <= 1'b0;
            dont_walk_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pending_q    <= pending_d;
            prev_green_q <= prev_green_d;
            walk_q       <= walk_d;
            dont_walk_q  <= dont_walk_d;
        end
    end

    // Lamps are decoded from the next state so they change on the same edge as the state register.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pending_d    = pending_q | req;
        green        = (light == LIGHT_GREEN);
        green_rise   = green & ~prev_green_q;
        prev_green_d = green;

        case (state_q)
            PED_DONT_WALK: begin
                if (green_rise && (pending_q || req)) begin
                    state_d   = PED_WALK;
                    cnt_d     = '0;
                    pending_d = 1'b0;
                end
            end
            PED_WALK: begin
                if (!green) begin
                    state_d = PED_DONT_WALK;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(T_WALK - 1)) begin
                    state_d = PED_FLASH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PED_FLASH: begin
                if (!green || (cnt_q == CNT_W'(T_FLASH - 1))) begin
                    state_d = PED_DONT_WALK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = PED_DONT_WALK;
                cnt_d   = '0;
            end
        endcase

        flash_phase = cnt_d / CNT_W'(FLASH_HALF);
        walk_d      = (state_d == PED_WALK);
        dont_walk_d = (state_d == PED_DONT_WALK) || ((state_d == PED_FLASH) && !flash_phase[0]);
    end

    assign walk      = walk_q;
    assign dont_walk = dont_walk_q;
    assign pending   = pending_q;

`ifdef PED_COUNTDOWN_EN
    logic [CNT_W-1:0] countdown_q, countdown_d;

    always_comb begin
        countdown_d = '0;
        if (state_d == PED_FLASH) begin
            countdown_d = CNT_W'(T_FLASH - 1) - cnt_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            countdown_q <= '0;
        end else begin
            countdown_q <= countdown_d;
        end
    end

    assign countdown = countdown_q;
`endif

endmodule

// File: rtl/ped_signal_ctrl.sv
// Pedestrian signal stage: two crosswalk channels driven by the traffic controller's light codes.
// Define PED_COUNTDOWN_EN to add the per-channel flash countdown outputs.
module ped_signal_ctrl
    import ped_pkg::*;
#(
    parameter int unsigned T_WALK     = 30,
    parameter int unsigned T_FLASH    = 16,
    parameter int unsigned FLASH_HALF = 4,
    parameter int unsigned CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       ns_light,
    input  logic [2:0]       ew_light,
    input  logic             ped_req_ns,
    input  logic             ped_req_ew,
    output logic             ns_walk,
    output logic             ns_dont_walk,
    output logic             ns_pending,
    output logic             ew_walk,
    output logic             ew_dont_walk,
    output logic             ew_pending,
    output logic             light_fault
`ifdef PED_COUNTDOWN_EN
    ,
    output logic [CNT_W-1:0] ns_countdown,
    output logic [CNT_W-1:0] ew_countdown
`endif
);

    logic light_fault_q, light_fault_d;

    ped_channel #(
        .T_WALK     (T_WALK),
        .T_FLASH    (T_FLASH),
        .FLASH_HALF (FLASH_HALF),
        .CNT_W      (CNT_W)
    ) u_ns (
        .clk       (clk),
        .rst       (rst),
        .light     (ns_light),
        .req       (ped_req_ns),
        .walk      (ns_walk),
        .dont_walk (ns_dont_walk),
        .pending   (ns_pending)
`ifdef PED_COUNTDOWN_EN
        ,
        .countdown (ns_countdown)
`endif
    );

    ped_channel #(
        .T_WALK     (T_WALK),
        .T_FLASH    (T_FLASH),
        .FLASH_HALF (FLASH_HALF),
        .CNT_W      (CNT_W)
    ) u_ew (
        .clk       (clk),
        .rst       (rst),
        .light     (ew_light),
        .req       (ped_req_ew),
        .walk      (ew_walk),
        .dont_walk (ew_dont_walk),
        .pending   (ew_pending)
`ifdef PED_COUNTDOWN_EN
        ,
        .countdown (ew_countdown)
`endif
    );

    // Sticky until reset; only observes the codes, never gates the channels.
    always_comb begin
        light_fault_d = light_fault_q | ~light_legal(ns_light) | ~light_legal(ew_light);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            light_fault_q <= 1'b0;
        end else begin
            light_fault_q <= light_fault_d;
        end
    end

    assign light_fault = light_fault_q;

endmodule
